// File: rtl/hash160_rmd_feeder.sv
// Feeds RIPEMD-160 blocks to the Hash160 round core: buffers SHA-256 digests,
// pads each into a little-endian 512-bit block, and issues them at the core's fixed cadence.
module hash160_rmd_feeder #(
    parameter int ISSUE_GAP     = 82,
    parameter int RESULT_OFFSET = 81,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic         clk_p_i,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [255:0] i_digest,
    output logic         o_ready,
    output logic         o_blk_valid,
    output logic [511:0] o_block,
    output logic         o_res_stb,
    output logic         o_busy,
    output logic [2:0]   o_fifo_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int GAP_W = $clog2(ISSUE_GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(ISSUE_GAP - 2);
    localparam logic [GAP_W-1:0] STB_MATCH = GAP_W'(ISSUE_GAP - RESULT_OFFSET);

    generate
        if (RESULT_OFFSET >= ISSUE_GAP || ISSUE_GAP < 3 || RESULT_OFFSET < 0) begin : g_bad_timing
            $error("hash160_rmd_feeder: need 0 <= RESULT_OFFSET < ISSUE_GAP and ISSUE_GAP >= 3");
        end
        if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4) begin : g_bad_depth
            $error("hash160_rmd_feeder: FIFO_DEPTH must be 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t             state_reg;
    logic [255:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [2:0]         cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic               blk_valid_reg;
    logic               res_stb_reg;
    logic [511:0]       block_reg;

    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic               gap_expired;
    logic [255:0]       head_digest;
    logic [511:0]       head_block;

    assign o_ready       = (cnt_reg < 3'(FIFO_DEPTH));
    assign push          = i_valid && o_ready;
    assign fifo_nonempty = (cnt_reg != 3'd0);
    assign gap_expired   = (gap_cnt_reg == '0);
    // The head leaves the FIFO exactly on the edge that enters ISSUE.
    assign pop           = fifo_nonempty &&
                           ((state_reg == ST_IDLE) || (state_reg == ST_WAIT && gap_expired));
    assign head_digest   = fifo_mem[rd_ptr_reg];

    // Each big-endian 32-bit chunk of the digest becomes one byte-swapped LE word.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word
            logic [31:0] chunk;
            assign chunk = head_digest[32*(7-gi) +: 32];
            assign head_block[32*gi +: 32] = {chunk[7:0], chunk[15:8], chunk[23:16], chunk[31:24]};
        end
    endgenerate
    assign head_block[511:256] = {32'h0000_0000, 32'h0000_0100, 160'h0, 32'h0000_0080};

    always_ff @(posedge clk_p_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= i_digest;
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 3'd1;
                2'b01:   cnt_reg <= cnt_reg - 3'd1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // The gap counter reads ISSUE_GAP-1-k in the k-th cycle after ISSUE, so
    // expiry lands one cycle before the next permitted ISSUE.
    always_ff @(posedge clk_p_i) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            gap_cnt_reg   <= '0;
            blk_valid_reg <= 1'b0;
            res_stb_reg   <= 1'b0;
            block_reg     <= '0;
        end else begin
            blk_valid_reg <= 1'b0;
            res_stb_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        state_reg     <= ST_ISSUE;
                        block_reg     <= head_block;
                        blk_valid_reg <= 1'b1;
                        if (RESULT_OFFSET == 0) begin
                            res_stb_reg <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    gap_cnt_reg <= GAP_LOAD;
                    state_reg   <= ST_WAIT;
                    if (RESULT_OFFSET == 1) begin
                        res_stb_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (RESULT_OFFSET >= 2 && gap_cnt_reg == STB_MATCH) begin
                        res_stb_reg <= 1'b1;
                    end
                    if (gap_expired) begin
                        if (pop) begin
                            state_reg     <= ST_ISSUE;
                            block_reg     <= head_block;
                            blk_valid_reg <= 1'b1;
                            if (RESULT_OFFSET == 0) begin
                                res_stb_reg <= 1'b1;
                            end
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_blk_valid = blk_valid_reg;
    assign o_block     = block_reg;
    assign o_res_stb   = res_stb_reg;
    assign o_fifo_cnt  = cnt_reg;
    assign o_busy      = (state_reg != ST_IDLE) || (cnt_reg != 3'd0);

endmodule

// File: tb/tb_hash160_rmd_feeder.sv
// Directed bench for hash160_rmd_feeder: reset, formatting, cadence, back-pressure
// and reset-abandon behaviour with hand-computed expected blocks and cycle numbers.
module tb_hash160_rmd_feeder;

    logic         clk_p_i = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [255:0] i_digest;
    logic         o_ready;
    logic         o_blk_valid;
    logic [511:0] o_block;
    logic         o_res_stb;
    logic         o_busy;
    logic [2:0]   o_fifo_cnt;

    hash160_rmd_feeder #(
        .ISSUE_GAP     (82),
        .RESULT_OFFSET (81),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk_p_i     (clk_p_i),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_digest    (i_digest),
        .o_ready     (o_ready),
        .o_blk_valid (o_blk_valid),
        .o_block     (o_block),
        .o_res_stb   (o_res_stb),
        .o_busy      (o_busy),
        .o_fifo_cnt  (o_fifo_cnt)
    );

    always #5 clk_p_i = ~clk_p_i;

    localparam logic [255:0] PAD = {32'h0, 32'h0000_0100, 160'h0, 32'h0000_0080};

    localparam logic [255:0] D0 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] E0 = {PAD, 32'h55b85278, 32'h1b9995a4, 32'h4c939b64, 32'he441ae27,
                                   32'h24b96f99, 32'hc8f4fb9a, 32'h141cfc98, 32'h42c4b0e3};
    localparam logic [255:0] D1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [511:0] E1 = {PAD, 32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                   32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    localparam logic [255:0] D2 = {32'hdeadbeef, 224'h0};
    localparam logic [511:0] E2 = {PAD, 224'h0, 32'hefbeadde};
    localparam logic [255:0] D3 = {224'h0, 32'h11223344};
    localparam logic [511:0] E3 = {PAD, 32'h44332211, 224'h0};
    localparam logic [255:0] D4 = {8{32'h5555aaaa}};
    localparam logic [511:0] E4 = {PAD, {8{32'haaaa5555}}};

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int t0;

    int           blk_q [$];
    int           stb_q [$];
    logic [511:0] blkv_q [$];

    always @(posedge clk_p_i) cyc <= cyc + 1;

    // Records the cycle of every pulse so cadence can be checked afterwards.
    always @(negedge clk_p_i) begin
        if (o_blk_valid === 1'b1) begin
            blk_q.push_back(cyc);
            blkv_q.push_back(o_block);
        end
        if (o_res_stb === 1'b1) begin
            stb_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_p_i);
            #1;
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic clear_log();
        blk_q.delete();
        stb_q.delete();
        blkv_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 512'(o_ready), 512'(1));
        check({tag, "_blk_valid"}, 512'(o_blk_valid), 512'(0));
        check({tag, "_block"}, o_block, 512'(0));
        check({tag, "_res_stb"}, 512'(o_res_stb), 512'(0));
        check({tag, "_busy"}, 512'(o_busy), 512'(0));
        check({tag, "_cnt"}, 512'(o_fifo_cnt), 512'(0));
    endtask

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_digest = '0;
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle: nothing happens for 200 cycles
        clear_log();
        step(200);
        check("idle_blk_pulses", 512'(blk_q.size()), 512'(0));
        check("idle_stb_pulses", 512'(stb_q.size()), 512'(0));
        check("idle_busy", 512'(o_busy), 512'(0));
        check("idle_ready", 512'(o_ready), 512'(1));
        check("idle_cnt", 512'(o_fifo_cnt), 512'(0));

        // Single digest SHA256("")
        clear_log();
        t0       = cyc;
        i_valid  = 1'b1;
        i_digest = D0;
        step(1);
        i_valid = 1'b0;
        check("single_cnt_t1", 512'(o_fifo_cnt), 512'(1));
        check("single_blk_t1", 512'(o_blk_valid), 512'(0));
        check("single_busy_t1", 512'(o_busy), 512'(1));
        step(1);
        check("single_blk_t2", 512'(o_blk_valid), 512'(1));
        check("single_block", o_block, E0);
        check("single_cnt_t2", 512'(o_fifo_cnt), 512'(0));
        step(40);
        check("single_hold_block", o_block, E0);
        check("single_hold_blk", 512'(o_blk_valid), 512'(0));
        check("single_wait_busy", 512'(o_busy), 512'(1));
        step_to(t0 + 90);
        check("single_nblk", 512'(blk_q.size()), 512'(1));
        check("single_blk_cycle", 512'(blk_q[0]), 512'(t0 + 2));
        check("single_nstb", 512'(stb_q.size()), 512'(1));
        check("single_stb_cycle", 512'(stb_q[0]), 512'(t0 + 83));
        check("single_end_busy", 512'(o_busy), 512'(0));

        // Burst of three, then a held fourth against a full FIFO
        clear_log();
        t0       = cyc;
        i_valid  = 1'b1;
        i_digest = D1;
        step(1);
        check("burst_ready_t1", 512'(o_ready), 512'(1));
        check("burst_cnt_t1", 512'(o_fifo_cnt), 512'(1));
        i_digest = D2;
        step(1);
        check("burst_blk_t2", 512'(o_blk_valid), 512'(1));
        check("burst_cnt_t2", 512'(o_fifo_cnt), 512'(1));
        i_digest = D3;
        step(1);
        check("burst_cnt_t3", 512'(o_fifo_cnt), 512'(2));
        check("burst_ready_t3", 512'(o_ready), 512'(0));
        i_digest = D4;
        step_to(t0 + 50);
        check("full_cnt_t50", 512'(o_fifo_cnt), 512'(2));
        check("full_ready_t50", 512'(o_ready), 512'(0));
        step_to(t0 + 83);
        check("full_cnt_t83", 512'(o_fifo_cnt), 512'(2));
        check("full_ready_t83", 512'(o_ready), 512'(0));
        step(1);
        check("pop_blk_t84", 512'(o_blk_valid), 512'(1));
        check("pop_cnt_t84", 512'(o_fifo_cnt), 512'(1));
        check("pop_ready_t84", 512'(o_ready), 512'(1));
        step(1);
        i_valid = 1'b0;
        check("refill_cnt_t85", 512'(o_fifo_cnt), 512'(2));
        check("refill_ready_t85", 512'(o_ready), 512'(0));
        step_to(t0 + 340);
        check("burst_nblk", 512'(blk_q.size()), 512'(4));
        check("burst_nstb", 512'(stb_q.size()), 512'(4));
        check("burst_blk0_cycle", 512'(blk_q[0]), 512'(t0 + 2));
        check("burst_blk1_cycle", 512'(blk_q[1]), 512'(t0 + 84));
        check("burst_blk2_cycle", 512'(blk_q[2]), 512'(t0 + 166));
        check("burst_blk3_cycle", 512'(blk_q[3]), 512'(t0 + 248));
        check("burst_stb0_cycle", 512'(stb_q[0]), 512'(t0 + 83));
        check("burst_stb3_cycle", 512'(stb_q[3]), 512'(t0 + 329));
        check("burst_block0", blkv_q[0], E1);
        check("burst_block1", blkv_q[1], E2);
        check("burst_block2", blkv_q[2], E3);
        check("burst_block3", blkv_q[3], E4);
        check("burst_end_busy", 512'(o_busy), 512'(0));

        // Reset 40 cycles into WAIT abandons the strobe
        clear_log();
        t0       = cyc;
        i_valid  = 1'b1;
        i_digest = D2;
        step(1);
        i_valid = 1'b0;
        step_to(t0 + 42);
        check("midrst_busy_before", 512'(o_busy), 512'(1));
        rst = 1'b1;
        step(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        step_to(t0 + 100);
        check("midrst_nstb", 512'(stb_q.size()), 512'(0));
        check("midrst_nblk", 512'(blk_q.size()), 512'(1));
        check("midrst_end_busy", 512'(o_busy), 512'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
